// File: rtl/error_reconstruct_if.sv
// Stream bundle for error_reconstruct.
// Purpose: collects the four streams around the reconstruction stage and the
// sticky error flag so that the block and its environment connect through one port.
//   kj_*         : Golomb parameter, block -> Golomb decoder
//   merr_*       : decoded mapped error and its slice/band/image last flags, decoder -> block
//   xtilde_in_*  : signed prediction and its slice last flag, predictor -> block
//   xhat_*       : reconstructed sample and forwarded last flags, block -> predictor
//   err_last_mismatch : sticky slice-boundary disagreement between merr and xtilde
// Modports: slave = the reconstruction block, master = its environment.
interface error_reconstruct_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ACC_LOG    = 5
);
    logic                    kj_valid;
    logic                    kj_ready;
    logic [ACC_LOG-1:0]      kj_data;

    logic                    merr_valid;
    logic                    merr_ready;
    logic [DATA_WIDTH+2:0]   merr_data;
    logic                    merr_last_s;
    logic                    merr_last_b;
    logic                    merr_last_i;

    logic                    xtilde_in_valid;
    logic                    xtilde_in_ready;
    logic [DATA_WIDTH+2:0]   xtilde_in_data;
    logic                    xtilde_in_last_s;

    logic                    xhat_valid;
    logic                    xhat_ready;
    logic [DATA_WIDTH-1:0]   xhat_data;
    logic                    xhat_last_s;
    logic                    xhat_last_b;
    logic                    xhat_last_i;

    logic                    err_last_mismatch;

    modport slave (
        output kj_valid, kj_data,
        input  kj_ready,
        input  merr_valid, merr_data, merr_last_s, merr_last_b, merr_last_i,
        output merr_ready,
        input  xtilde_in_valid, xtilde_in_data, xtilde_in_last_s,
        output xtilde_in_ready,
        output xhat_valid, xhat_data, xhat_last_s, xhat_last_b, xhat_last_i,
        input  xhat_ready,
        output err_last_mismatch
    );

    modport master (
        input  kj_valid, kj_data,
        output kj_ready,
        output merr_valid, merr_data, merr_last_s, merr_last_b, merr_last_i,
        input  merr_ready,
        output xtilde_in_valid, xtilde_in_data, xtilde_in_last_s,
        input  xtilde_in_ready,
        input  xhat_valid, xhat_data, xhat_last_s, xhat_last_b, xhat_last_i,
        output xhat_ready,
        input  err_last_mismatch
    );
endinterface

// File: rtl/error_reconstruct.sv
// Decoder-side error reconstruction.
// Purpose: per sample, offers the Golomb parameter kj derived from the running
// mapped-error accumulator, then joins the decoded mapped error with the prediction
// and produces the reconstructed sample xhat (clamped to [0, 2^DATA_WIDTH-1]).
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : error_reconstruct_if.slave (kj, merr, xtilde_in, xhat streams + mismatch flag)
module error_reconstruct #(
    parameter int unsigned DATA_WIDTH         = 16,
    parameter int unsigned ACCUMULATOR_WINDOW = 32,
    parameter int unsigned ACC_LOG            = 5,
    parameter int unsigned THRESHOLD          = 0
) (
    input  logic               clk,
    input  logic               rst,
    error_reconstruct_if.slave bus
);
    localparam int unsigned MW     = DATA_WIDTH + 3;
    localparam int unsigned WinLog = $clog2(ACCUMULATOR_WINDOW);
    localparam int unsigned AccW   = MW + WinLog + 1;
    localparam int unsigned CntW   = WinLog + 1;
    localparam int unsigned KCapA  = (1 << ACC_LOG) - 1;
    localparam int unsigned KMax   = (KCapA < DATA_WIDTH + 2) ? KCapA : DATA_WIDTH + 2;
    localparam int unsigned ShW    = AccW + KMax;
    // Wide enough for (clamped prediction) + (error * quantizer step) without overflow.
    localparam int unsigned RW     = MW + 36;

    localparam logic signed [RW-1:0] XMaxS =
        {{(RW - DATA_WIDTH){1'b0}}, {DATA_WIDTH{1'b1}}};
    localparam logic signed [RW-1:0] StepS = RW'(2 * THRESHOLD + 1);

    typedef enum logic [1:0] {StCalc, StKj, StJoin, StOut} state_e;

    state_e                  state_q, state_d;
    logic [AccW-1:0]         acc_q, acc_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [ACC_LOG-1:0]      kj_q, kj_d;
    logic [DATA_WIDTH-1:0]   xhat_q, xhat_d;
    logic                    last_s_q, last_s_d;
    logic                    last_b_q, last_b_d;
    logic                    last_i_q, last_i_d;
    logic                    mismatch_q, mismatch_d;

    logic                    join_ok;
    logic [ACC_LOG-1:0]      kj_calc;
    logic [AccW-1:0]         acc_upd;
    logic [CntW-1:0]         cnt_upd;
    logic [DATA_WIDTH-1:0]   xhat_calc;
    logic signed [RW-1:0]    merr_ext, e_s, xt_ext, p_s, sum_s;

    assign join_ok = (state_q == StJoin) && bus.merr_valid && bus.xtilde_in_valid;

    // Smallest k with (cnt << k) >= acc; scanning downwards leaves the smallest hit.
    always_comb begin
        kj_calc = ACC_LOG'(KMax);
        for (int k = int'(KMax); k >= 0; k--) begin
            if ((ShW'(cnt_q) << k) >= ShW'(acc_q)) begin
                kj_calc = ACC_LOG'(k);
            end
        end
        if (cnt_q == '0) begin
            kj_calc = '0;
        end
    end

    // Unmap the error, clamp the prediction, scale by the quantizer step and clamp again.
    always_comb begin
        merr_ext = {{(RW - MW){1'b0}}, bus.merr_data};
        e_s      = merr_ext[0] ? -((merr_ext + 1) >>> 1) : (merr_ext >>> 1);
        xt_ext   = {{(RW - MW){bus.xtilde_in_data[MW-1]}}, bus.xtilde_in_data};
        if (xt_ext[RW-1]) begin
            p_s = '0;
        end else if (xt_ext > XMaxS) begin
            p_s = XMaxS;
        end else begin
            p_s = xt_ext;
        end
        sum_s = p_s + e_s * StepS;
        if (sum_s[RW-1]) begin
            xhat_calc = '0;
        end else if (sum_s > XMaxS) begin
            xhat_calc = '1;
        end else begin
            xhat_calc = sum_s[DATA_WIDTH-1:0];
        end
    end

    // Accumulator update; a slice end wins over window halving.
    always_comb begin
        acc_upd = acc_q + AccW'(bus.merr_data);
        cnt_upd = cnt_q + CntW'(1);
        if (cnt_upd == CntW'(ACCUMULATOR_WINDOW)) begin
            acc_upd = acc_upd >> 1;
            cnt_upd = cnt_upd >> 1;
        end
        if (bus.merr_last_s) begin
            acc_upd = '0;
            cnt_upd = '0;
        end
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        kj_d       = kj_q;
        xhat_d     = xhat_q;
        last_s_d   = last_s_q;
        last_b_d   = last_b_q;
        last_i_d   = last_i_q;
        mismatch_d = mismatch_q;
        unique case (state_q)
            StCalc: begin
                kj_d    = kj_calc;
                state_d = StKj;
            end
            StKj: begin
                if (bus.kj_ready) begin
                    state_d = StJoin;
                end
            end
            StJoin: begin
                if (join_ok) begin
                    xhat_d   = xhat_calc;
                    last_s_d = bus.merr_last_s;
                    last_b_d = bus.merr_last_b;
                    last_i_d = bus.merr_last_i;
                    acc_d    = acc_upd;
                    cnt_d    = cnt_upd;
                    if (bus.merr_last_s != bus.xtilde_in_last_s) begin
                        mismatch_d = 1'b1;
                    end
                    state_d = StOut;
                end
            end
            StOut: begin
                if (bus.xhat_ready) begin
                    state_d = StCalc;
                end
            end
            default: state_d = StCalc;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StCalc;
            acc_q      <= '0;
            cnt_q      <= '0;
            kj_q       <= '0;
            xhat_q     <= '0;
            last_s_q   <= 1'b0;
            last_b_q   <= 1'b0;
            last_i_q   <= 1'b0;
            mismatch_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            kj_q       <= kj_d;
            xhat_q     <= xhat_d;
            last_s_q   <= last_s_d;
            last_b_q   <= last_b_d;
            last_i_q   <= last_i_d;
            mismatch_q <= mismatch_d;
        end
    end

    assign bus.kj_valid          = (state_q == StKj);
    assign bus.kj_data           = kj_q;
    assign bus.merr_ready        = join_ok;
    assign bus.xtilde_in_ready   = join_ok;
    assign bus.xhat_valid        = (state_q == StOut);
    assign bus.xhat_data         = xhat_q;
    assign bus.xhat_last_s       = last_s_q;
    assign bus.xhat_last_b       = last_b_q;
    assign bus.xhat_last_i       = last_i_q;
    assign bus.err_last_mismatch = mismatch_q;
endmodule

// File: tb/tb_error_reconstruct.sv
// Bench for error_reconstruct: two instances (THRESHOLD 0 and 1) driven in lockstep.
module tb_error_reconstruct;
    localparam int DW    = 16;
    localparam int MW    = DW + 3;
    localparam int WIN   = 32;
    localparam int KMAX  = 18;
    localparam int LIMIT = 200;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic kj_ready = 1'b0, merr_valid = 1'b0, xt_valid = 1'b0, xhat_ready = 1'b0;
    logic [MW-1:0] merr_data = '0, xt_data = '0;
    logic m_ls = 1'b0, m_lb = 1'b0, m_li = 1'b0, x_ls = 1'b0;

    error_reconstruct_if #(.DATA_WIDTH(DW), .ACC_LOG(5)) if0 ();
    error_reconstruct_if #(.DATA_WIDTH(DW), .ACC_LOG(5)) if1 ();

    assign if0.kj_ready = kj_ready;         assign if1.kj_ready = kj_ready;
    assign if0.merr_valid = merr_valid;     assign if1.merr_valid = merr_valid;
    assign if0.merr_data = merr_data;       assign if1.merr_data = merr_data;
    assign if0.merr_last_s = m_ls;          assign if1.merr_last_s = m_ls;
    assign if0.merr_last_b = m_lb;          assign if1.merr_last_b = m_lb;
    assign if0.merr_last_i = m_li;          assign if1.merr_last_i = m_li;
    assign if0.xtilde_in_valid = xt_valid;  assign if1.xtilde_in_valid = xt_valid;
    assign if0.xtilde_in_data = xt_data;    assign if1.xtilde_in_data = xt_data;
    assign if0.xtilde_in_last_s = x_ls;     assign if1.xtilde_in_last_s = x_ls;
    assign if0.xhat_ready = xhat_ready;     assign if1.xhat_ready = xhat_ready;

    error_reconstruct #(.DATA_WIDTH(DW), .ACCUMULATOR_WINDOW(WIN), .ACC_LOG(5), .THRESHOLD(0))
        dut0 (.clk(clk), .rst(rst), .bus(if0));
    error_reconstruct #(.DATA_WIDTH(DW), .ACCUMULATOR_WINDOW(WIN), .ACC_LOG(5), .THRESHOLD(1))
        dut1 (.clk(clk), .rst(rst), .bus(if1));

    always #5 clk = ~clk;

    typedef struct {
        int         x0;
        int         x1;
        logic [2:0] fl;
    } exp_t;

    exp_t   xq[$];
    int     kq[$];
    int     vectors = 0;
    int     miscompares = 0;
    longint acc_m = 0, cnt_m = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic abort(input string phase);
        miscompares++;
        $display("FAIL timeout waiting in %s phase", phase);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "bench aborted");
    endtask

    function automatic int model_kj();
        if (cnt_m == 0) return 0;
        for (int k = 0; k <= KMAX; k++) begin
            if ((cnt_m << k) >= acc_m) return k;
        end
        return KMAX;
    endfunction

    function automatic int model_xhat(input longint merr, input longint xt, input int thr);
        longint e, p, s;
        e = (merr % 2 == 0) ? merr / 2 : -((merr + 1) / 2);
        p = (xt < 0) ? 0 : (xt > 65535) ? 65535 : xt;
        s = p + e * (2 * thr + 1);
        if (s < 0) s = 0;
        if (s > 65535) s = 65535;
        return int'(s);
    endfunction

    // Scoreboard side: compare whenever a handshake is about to complete.
    logic [4:0] kj_hold = '0;
    logic       kj_hold_v = 1'b0;
    always @(negedge clk) begin
        exp_t ex;
        int   ek;
        if (rst) begin
            if (!(merr_valid && xt_valid)) begin
                check("join_alone", {if0.merr_ready, if0.xtilde_in_ready,
                                     if1.merr_ready, if1.xtilde_in_ready}, 0);
            end
            if (kj_hold_v && if0.kj_valid) check("kj_stable", if0.kj_data, kj_hold);
            kj_hold_v = if0.kj_valid && !kj_ready;
            kj_hold   = if0.kj_data;
            if (if0.kj_valid && kj_ready) begin
                check("kj_queue", kq.size() > 0, 1);
                if (kq.size() > 0) begin
                    ek = kq.pop_front();
                    check("kj0", if0.kj_data, ek);
                    check("kj1", {if1.kj_valid, if1.kj_data}, {1'b1, 5'(ek)});
                end
            end
            if (if0.xhat_valid && xhat_ready) begin
                check("xhat_queue", xq.size() > 0, 1);
                if (xq.size() > 0) begin
                    ex = xq.pop_front();
                    check("xhat0", if0.xhat_data, ex.x0);
                    check("xhat1", {if1.xhat_valid, if1.xhat_data}, {1'b1, 16'(ex.x1)});
                    check("flags0", {if0.xhat_last_s, if0.xhat_last_b, if0.xhat_last_i}, ex.fl);
                    check("flags1", {if1.xhat_last_s, if1.xhat_last_b, if1.xhat_last_i}, ex.fl);
                end
            end
        end else begin
            kj_hold_v = 1'b0;
        end
    end

    // One sample through kj, join and output phases. Negative ek/e0/e1 use the model.
    task automatic sample(input int merr, input int xt, input bit ls, input bit lb,
                          input bit li, input bit xls, input bit rnd, input int ek,
                          input int e0, input int e1, input bit hold);
        int   n;
        exp_t ex;
        kq.push_back(ek >= 0 ? ek : model_kj());
        ex.x0 = (e0 >= 0) ? e0 : model_xhat(merr, xt, 0);
        ex.x1 = (e1 >= 0) ? e1 : model_xhat(merr, xt, 1);
        ex.fl = {ls, lb, li};
        xq.push_back(ex);
        acc_m += merr;
        cnt_m += 1;
        if (cnt_m == WIN) begin
            acc_m = acc_m >> 1;
            cnt_m = cnt_m >> 1;
        end
        if (ls) begin
            acc_m = 0;
            cnt_m = 0;
        end

        n = 0;
        forever begin
            kj_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (if0.kj_valid && kj_ready) break;
            n++;
            if (n > LIMIT) abort("kj");
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        kj_ready = 1'b0;

        merr_data = MW'(merr);
        xt_data   = MW'(xt);
        m_ls = ls; m_lb = lb; m_li = li; x_ls = xls;
        n = 0;
        forever begin
            if (!merr_valid) merr_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (!xt_valid) xt_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (if0.merr_ready) break;
            n++;
            if (n > LIMIT) abort("join");
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        merr_valid = 1'b0;
        xt_valid   = 1'b0;

        if (hold) begin
            @(negedge clk);
            check("xhat_valid_pending", if0.xhat_valid, 1);
            return;
        end
        n = 0;
        forever begin
            xhat_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (if0.xhat_valid && xhat_ready) break;
            n++;
            if (n > LIMIT) abort("xhat");
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        xhat_ready = 1'b0;
    endtask

    initial begin
        int merr, xt;
        bit ls;
        #3;
        check("rst_valids0", {if0.kj_valid, if0.xhat_valid, if0.merr_ready, if0.xtilde_in_ready}, 0);
        check("rst_valids1", {if1.kj_valid, if1.xhat_valid, if1.merr_ready, if1.xtilde_in_ready}, 0);
        check("rst_data0", {if0.kj_data, if0.xhat_data}, 0);
        check("rst_flags0", {if0.xhat_last_s, if0.xhat_last_b, if0.xhat_last_i,
                             if0.err_last_mismatch}, 0);
        check("rst_flags1", {if1.xhat_last_s, if1.xhat_last_b, if1.xhat_last_i,
                             if1.err_last_mismatch}, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Basic reconstruction; dut1 sees step 3.
        sample(0, 100, 0, 0, 0, 0, 0, 0, 100, 100, 0);
        sample(4, 100, 0, 0, 0, 0, 0, -1, 102, 106, 0);
        sample(5, 100, 0, 0, 0, 0, 0, -1, 97, 91, 0);
        sample(0, 0, 1, 0, 0, 1, 0, -1, 0, 0, 0);

        // kj sequence and slice reset.
        sample(8, 1000, 0, 0, 0, 0, 0, 0, 1004, 1012, 0);
        sample(0, 1000, 0, 0, 0, 0, 0, 3, 1000, 1000, 0);
        sample(4, 1000, 1, 0, 0, 1, 0, 2, 1002, 1006, 0);
        sample(3, 1000, 0, 0, 0, 0, 0, 0, 998, 994, 0);

        // Clamps.
        sample(20, 65534, 0, 0, 0, 0, 0, -1, 65535, 65535, 0);
        sample(0, -5, 0, 0, 0, 0, 0, -1, 0, 0, 0);
        sample(1, 70000, 0, 0, 0, 0, 0, -1, 65534, 65532, 0);
        sample(6, 500, 1, 1, 1, 1, 0, -1, 503, 509, 0);

        // Window halving: acc 64/cnt 32 -> 32/16 -> kj 1.
        for (int i = 0; i < WIN; i++) sample(2, 2000, 0, 0, 0, 0, 0, -1, 2001, 2003, 0);
        sample(0, 2000, 0, 0, 0, 0, 0, 1, 2000, 2000, 0);

        // Random data with random stalls on every handshake.
        for (int i = 0; i < 40; i++) begin
            merr = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, (1 << MW) - 1))
                                               : int'($urandom_range(0, 600));
            xt   = int'($urandom_range(0, 80000)) - 5000;
            ls   = ($urandom_range(0, 7) == 0);
            sample(merr, xt, ls, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ls,
                   1, -1, -1, -1, 0);
        end

        // Sticky last-of-slice mismatch.
        check("mismatch_clear", {if0.err_last_mismatch, if1.err_last_mismatch}, 2'b00);
        sample(2, 300, 0, 0, 0, 1, 0, -1, 301, 303, 0);
        check("mismatch_set", {if0.err_last_mismatch, if1.err_last_mismatch}, 2'b11);
        sample(1, 300, 0, 0, 0, 0, 0, -1, 299, 297, 0);
        check("mismatch_sticky", {if0.err_last_mismatch, if1.err_last_mismatch}, 2'b11);

        // Reset while an output is pending.
        sample(10, 400, 0, 0, 0, 0, 0, -1, 405, 415, 1);
        #2 rst = 1'b0;
        #1;
        check("rst_out_valid", {if0.xhat_valid, if1.xhat_valid, if0.kj_valid, if1.kj_valid}, 0);
        check("rst_mismatch", {if0.err_last_mismatch, if1.err_last_mismatch}, 2'b00);
        xq.delete();
        acc_m = 0;
        cnt_m = 0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        sample(7, 400, 0, 0, 0, 0, 0, 0, 396, 388, 0);
        sample(9, 400, 0, 0, 0, 0, 0, -1, -1, -1, 0);

        check("kj_drained", kq.size(), 0);
        check("xhat_drained", xq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
